// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequencer for a single PE.
// Loads the ifmap, filter and psum-bias scratchpads from one input stream.
// Runs a 1-D stride-1 convolution row on the PE.
// Streams the finished psums out through a valid/ready port.
module pe_seq_ctrl #(
    parameter int DW      = 16,
    parameter int MAC_GAP = 2,
    parameter int RD_LAT  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    cfg_s,
    input  logic [4:0]    cfg_nout,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          en,
    output logic [3:0]    addr_ifmap,
    output logic [7:0]    addr_filter,
    output logic [4:0]    addr_psum,
    output logic          wr_en_ifmap,
    output logic          wr_en_filter,
    output logic          wr_en_psum,
    output logic [DW-1:0] input_ifmap,
    output logic [DW-1:0] input_filter,
    output logic [DW-1:0] input_psum,
    input  logic [DW-1:0] output_psum
);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_LD_IF   = 4'd1;
    localparam logic [3:0] ST_LD_FL   = 4'd2;
    localparam logic [3:0] ST_LD_PS   = 4'd3;
    localparam logic [3:0] ST_MAC     = 4'd4;
    localparam logic [3:0] ST_GAP     = 4'd5;
    localparam logic [3:0] ST_RD_ADDR = 4'd6;
    localparam logic [3:0] ST_RD_WAIT = 4'd7;
    localparam logic [3:0] ST_OUT     = 4'd8;

    logic [3:0]    state;
    logic [3:0]    ifm_last;
    logic [3:0]    s_last;
    logic [3:0]    n_last;
    logic [3:0]    ld_cnt;
    logic [3:0]    o_cnt;
    logic [3:0]    k_cnt;
    logic [7:0]    gap_cnt;
    logic [7:0]    wait_cnt;
    logic [DW-1:0] out_q;
    logic          done_q;
    logic          err_q;

    logic [5:0]    cfg_sum;
    logic          cfg_bad;
    logic          beat;
    logic          mac_step;

    // Validate the requested geometry and decode the load handshake and MAC advance points.
    always_comb begin
        cfg_sum  = {1'b0, cfg_nout} + {2'b00, cfg_s};
        cfg_bad  = (cfg_s == 4'd0) || (cfg_nout == 5'd0) || (cfg_nout > 5'd16) || (cfg_sum > 6'd17);
        beat     = in_valid && in_ready;
        mac_step = ((state == ST_MAC) && (MAC_GAP == 1)) ||
                   ((state == ST_GAP) && (gap_cnt == 8'd1));
    end

    // Main sequencer; the MAC loop advance is applied after the state case so it covers both MAC and GAP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ifm_last <= '0;
            s_last   <= '0;
            n_last   <= '0;
            ld_cnt   <= '0;
            o_cnt    <= '0;
            k_cnt    <= '0;
            gap_cnt  <= '0;
            wait_cnt <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            ifm_last <= 4'(cfg_sum - 6'd2);
                            s_last   <= cfg_s - 4'd1;
                            n_last   <= 4'(cfg_nout - 5'd1);
                            ld_cnt   <= '0;
                            o_cnt    <= '0;
                            k_cnt    <= '0;
                            state    <= ST_LD_IF;
                        end
                    end
                end
                ST_LD_IF: begin
                    if (beat) begin
                        if (ld_cnt == ifm_last) begin
                            ld_cnt <= '0;
                            state  <= ST_LD_FL;
                        end else begin
                            ld_cnt <= ld_cnt + 4'd1;
                        end
                    end
                end
                ST_LD_FL: begin
                    if (beat) begin
                        if (ld_cnt == s_last) begin
                            ld_cnt <= '0;
                            state  <= ST_LD_PS;
                        end else begin
                            ld_cnt <= ld_cnt + 4'd1;
                        end
                    end
                end
                ST_LD_PS: begin
                    if (beat) begin
                        if (ld_cnt == n_last) begin
                            ld_cnt <= '0;
                            state  <= ST_MAC;
                        end else begin
                            ld_cnt <= ld_cnt + 4'd1;
                        end
                    end
                end
                ST_MAC: begin
                    if (MAC_GAP > 1) begin
                        gap_cnt <= 8'(MAC_GAP - 1);
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != 8'd1) begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                ST_RD_ADDR: begin
                    if (RD_LAT == 0) begin
                        out_q <= output_psum;
                        state <= ST_OUT;
                    end else begin
                        wait_cnt <= 8'(RD_LAT);
                        state    <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (wait_cnt == 8'd1) begin
                        out_q <= output_psum;
                        state <= ST_OUT;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (o_cnt == n_last) begin
                            done_q <= 1'b1;
                            o_cnt  <= '0;
                            state  <= ST_IDLE;
                        end else begin
                            o_cnt <= o_cnt + 4'd1;
                            state <= ST_RD_ADDR;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (mac_step) begin
                if (k_cnt == s_last) begin
                    k_cnt <= '0;
                    if (o_cnt == n_last) begin
                        o_cnt <= '0;
                        state <= ST_RD_ADDR;
                    end else begin
                        o_cnt <= o_cnt + 4'd1;
                        state <= ST_MAC;
                    end
                end else begin
                    k_cnt <= k_cnt + 4'd1;
                    state <= ST_MAC;
                end
            end
        end
    end

    // PE-side and stream outputs decoded from the state; out_valid depends only on state, never on out_ready.
    always_comb begin
        in_ready     = (state == ST_LD_IF) || (state == ST_LD_FL) || (state == ST_LD_PS);
        wr_en_ifmap  = (state == ST_LD_IF) && in_valid;
        wr_en_filter = (state == ST_LD_FL) && in_valid;
        wr_en_psum   = (state == ST_LD_PS) && in_valid;
        input_ifmap  = in_data;
        input_filter = in_data;
        input_psum   = in_data;
        en           = (state == ST_MAC);
        busy         = (state != ST_IDLE);
        out_valid    = (state == ST_OUT);
        out_data     = out_q;
        done         = done_q;
        err          = err_q;
        addr_ifmap   = '0;
        addr_filter  = '0;
        addr_psum    = '0;
        case (state)
            ST_LD_IF: addr_ifmap  = ld_cnt;
            ST_LD_FL: addr_filter = {4'd0, ld_cnt};
            ST_LD_PS: addr_psum   = {1'b0, ld_cnt};
            ST_MAC, ST_GAP: begin
                addr_ifmap  = o_cnt + k_cnt;
                addr_filter = {4'd0, k_cnt};
                addr_psum   = {1'b0, o_cnt};
            end
            ST_RD_ADDR, ST_RD_WAIT, ST_OUT: addr_psum = {1'b0, o_cnt};
            default: ;
        endcase
    end

endmodule
